sat_accumulator: RTL and testbench
==================================

SAT_ACCUMULATOR -- requirements
Module: sat_accumulator

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 16, bits per channel word (two's complement, Q format with INT_BITS integer bits).
REQ-002 SHALL have parameter INT_BITS, default 8, integer bits; fixed-point position only, no effect on arithmetic.
REQ-003 SHALL have parameter CHANNELS, default 4, independent accumulator lanes.
REQ-004 SHALL have parameter ACC_LEN, default 8, accepted beats per accumulation window (>=1).
REQ-005 SHALL have parameter SATURATE, default 1: 1 = clamp on overflow/underflow, 0 = wrap.
REQ-006 SHALL have port clk_i, input, 1, sole clock; all state on rising edge.
REQ-007 SHALL have port reset_n_i, input, 1; one clock, asynchronous active-low reset.
REQ-008 SHALL have port valid_i, input, 1, input beat valid.
REQ-009 SHALL have port ready_o, output, 1, block accepts beat.
REQ-010 SHALL have port data_i, input, CHANNELS*WORD_SIZE, channel c at bits [c*WORD_SIZE +: WORD_SIZE].
REQ-011 SHALL have port clear_flags_i, input, 1, clears sticky flags.
REQ-012 SHALL have port valid_o, output, 1, result valid.
REQ-013 SHALL have port ready_i, input, 1, downstream accepts result.
REQ-014 SHALL have port data_o, output, CHANNELS*WORD_SIZE, packed like data_i.
REQ-015 SHALL have ports overflow_o and underflow_o, output, CHANNELS each, per-window event bits, qualified by valid_o.
REQ-016 SHALL have ports overflow_flag_o and underflow_flag_o, output, CHANNELS each, sticky flags.

Function
REQ-017 SHALL implement a two-state FSM: ACCUM (ready_o=1, valid_o=0) and OUTPUT (ready_o=0, valid_o=1).
REQ-018 Beat accepted iff valid_i && ready_o; each accepted beat adds data_i lane c to accumulator c, all lanes in the same cycle.
REQ-019 SHALL keep a beat counter 0..ACC_LEN-1; the ACC_LEN-th accepted beat moves ACCUM->OUTPUT; data_o is valid the next cycle (1-cycle latency).
REQ-020 Overflow per lane: both operands non-negative, raw WORD_SIZE sum negative; underflow: both negative, raw sum non-negative.
REQ-021 SATURATE=1: overflow result = 2^(WORD_SIZE-1)-1, underflow result = -2^(WORD_SIZE-1); later beats continue from the clamped value.
REQ-022 SATURATE=0: result = raw sum modulo 2^WORD_SIZE.
REQ-023 overflow_o[c]/underflow_o[c] SHALL be set if that event occurred on any beat of the window; both may be set in one window.
REQ-024 In OUTPUT, data_o and window bits SHALL hold stable until ready_i=1; that cycle returns to ACCUM with accumulators, counter and window bits zeroed.
REQ-025 valid_i in OUTPUT SHALL be ignored (no accumulation, no counter change).
REQ-026 overflow_flag_o[c] SHALL set on a lane-c overflow only if underflow_flag_o[c]=0; underflow_flag_o[c] likewise mirrored (first event wins, flags never both 1).
REQ-027 Sticky flags SHALL hold until reset or clear_flags_i; clear_flags_i with same-cycle event: flags are cleared then the event sets its flag (event not lost).
REQ-028 ACC_LEN=1 SHALL output every accepted beat as a one-beat window.

Reset
REQ-029 reset_n_i low SHALL asynchronously force state ACCUM, counter 0, all accumulators, data_o, window bits, sticky flags, valid_o to 0; ready_o=1.
REQ-030 Reset mid-window or in OUTPUT SHALL discard partial sums and the pending result; first beat after release starts a new window.

Verification (WORD_SIZE=16, CHANNELS=2, ACC_LEN=4)
REQ-031 Reset: assert reset_n_i=0 asynchronously -> all outputs 0, ready_o=1 without a clock edge.
REQ-032 Normal: lane0 0x0100 x4, lane1 0xFF00 x4 -> next cycle valid_o=1, data_o lane0=0x0400, lane1=0xFC00, no flags.
REQ-033 SATURATE=1: lane0 0x7000 x4, lane1 0x9000 x4 -> lane0=0x7FFF, overflow_o[0]=1, overflow_flag_o[0]=1; lane1=0x8000, underflow_o[1]=1, underflow_flag_o[1]=1.
REQ-034 SATURATE=0: lane0 0x7000,0x7000,0,0 -> lane0=0xE000, overflow_o[0]=1.
REQ-035 Backpressure: ready_i=0 for 3 cycles with valid_i=1 -> data_o stable, ready_o=0, no beats counted; ready_i=1 -> ACCUM, next window starts from zero.
REQ-036 Sticky: lane0 underflow window then overflow window -> underflow_flag_o[0]=1, overflow_flag_o[0]=0; clear_flags_i pulse -> both 0; reset after 2 beats -> new 4-beat window sums only post-reset beats.

Source files
------------

// File: rtl/sat_accumulator.sv
// Multi-lane windowed accumulator with optional saturation.
// Sums ACC_LEN accepted beats per lane, then presents the result until downstream takes it.
module sat_accumulator #(
  parameter int WORD_SIZE = 16,
  parameter int INT_BITS  = 8,
  parameter int CHANNELS  = 4,
  parameter int ACC_LEN   = 8,
  parameter int SATURATE  = 1
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  input  logic                          valid_i,
  output logic                          ready_o,
  input  logic [CHANNELS*WORD_SIZE-1:0] data_i,
  input  logic                          clear_flags_i,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic [CHANNELS*WORD_SIZE-1:0] data_o,
  output logic [CHANNELS-1:0]           overflow_o,
  output logic [CHANNELS-1:0]           underflow_o,
  output logic [CHANNELS-1:0]           overflow_flag_o,
  output logic [CHANNELS-1:0]           underflow_flag_o
);

  localparam int CNT_W = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(ACC_LEN - 1);
  localparam logic [WORD_SIZE-1:0] MAX_POS = {1'b0, {(WORD_SIZE-1){1'b1}}};
  localparam logic [WORD_SIZE-1:0] MAX_NEG = {1'b1, {(WORD_SIZE-1){1'b0}}};

  typedef enum logic {ST_ACCUM, ST_OUTPUT} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic             w_accept;
  logic             w_last;
  logic             w_release;

  assign w_accept  = valid_i && (r_state == ST_ACCUM);
  assign w_last    = w_accept && (r_cnt == LAST_BEAT);
  assign w_release = (r_state == ST_OUTPUT) && ready_i;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state <= ST_ACCUM;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    ready_o      = 1'b0;
    valid_o      = 1'b0;
    case (r_state)
      ST_ACCUM: begin
        ready_o = 1'b1;
        if (w_last) begin
          w_state_next = ST_OUTPUT;
        end
      end
      ST_OUTPUT: begin
        valid_o = 1'b1;
        if (ready_i) begin
          w_state_next = ST_ACCUM;
        end
      end
      default: w_state_next = ST_ACCUM;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_cnt <= '0;
    end else if (w_release) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= w_last ? '0 : r_cnt + 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_lane
      logic [WORD_SIZE-1:0] r_acc;
      logic                 r_win_ovf;
      logic                 r_win_unf;
      logic                 r_flag_ovf;
      logic                 r_flag_unf;
      logic [WORD_SIZE-1:0] w_d;
      logic [WORD_SIZE-1:0] w_sum;
      logic [WORD_SIZE-1:0] w_res;
      logic                 w_ovf;
      logic                 w_unf;
      logic                 w_ev_ovf;
      logic                 w_ev_unf;
      logic                 w_base_ovf;
      logic                 w_base_unf;

      assign w_d   = data_i[gi*WORD_SIZE +: WORD_SIZE];
      assign w_sum = r_acc + w_d;
      assign w_ovf = !r_acc[WORD_SIZE-1] && !w_d[WORD_SIZE-1] &&  w_sum[WORD_SIZE-1];
      assign w_unf =  r_acc[WORD_SIZE-1] &&  w_d[WORD_SIZE-1] && !w_sum[WORD_SIZE-1];

      if (SATURATE != 0) begin : g_sat
        assign w_res = w_ovf ? MAX_POS : (w_unf ? MAX_NEG : w_sum);
      end else begin : g_wrap
        assign w_res = w_sum;
      end

      assign w_ev_ovf = w_accept && w_ovf;
      assign w_ev_unf = w_accept && w_unf;

      // A clear in the same cycle as an event must not swallow that event.
      assign w_base_ovf = clear_flags_i ? 1'b0 : r_flag_ovf;
      assign w_base_unf = clear_flags_i ? 1'b0 : r_flag_unf;

      always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
          r_acc     <= '0;
          r_win_ovf <= 1'b0;
          r_win_unf <= 1'b0;
        end else if (w_release) begin
          r_acc     <= '0;
          r_win_ovf <= 1'b0;
          r_win_unf <= 1'b0;
        end else if (w_accept) begin
          r_acc     <= w_res;
          r_win_ovf <= r_win_ovf | w_ovf;
          r_win_unf <= r_win_unf | w_unf;
        end
      end

      always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
          r_flag_ovf <= 1'b0;
          r_flag_unf <= 1'b0;
        end else begin
          r_flag_ovf <= w_base_ovf | (w_ev_ovf & ~w_base_unf);
          r_flag_unf <= w_base_unf | (w_ev_unf & ~w_base_ovf);
        end
      end

      assign data_o[gi*WORD_SIZE +: WORD_SIZE] = r_acc;
      assign overflow_o[gi]       = r_win_ovf;
      assign underflow_o[gi]      = r_win_unf;
      assign overflow_flag_o[gi]  = r_flag_ovf;
      assign underflow_flag_o[gi] = r_flag_unf;
    end
  endgenerate

  logic w_unused;
  assign w_unused = (INT_BITS < 0);

endmodule

// File: tb/tb_sat_accumulator.sv
// Directed bench for sat_accumulator: one saturating and one wrapping instance share stimulus,
// an integer-range reference model fills a result queue checked when valid_o appears.
module tb_sat_accumulator;

  localparam int W = 16;
  localparam int C = 2;

  logic clk = 1'b0;
  logic reset_n_i = 1'b0;
  logic valid_i = 1'b0;
  logic [C*W-1:0] data_i = '0;
  logic clear_flags_i = 1'b0;
  logic ready_i = 1'b0;

  logic           ready_s, valid_s, ready_w, valid_w;
  logic [C*W-1:0] data_s, data_w;
  logic [C-1:0]   ov_s, un_s, fo_s, fu_s, ov_w, un_w, fo_w, fu_w;

  always #5 clk = ~clk;

  sat_accumulator #(.WORD_SIZE(W), .INT_BITS(8), .CHANNELS(C), .ACC_LEN(4), .SATURATE(1)) u_sat (
    .clk_i(clk), .reset_n_i(reset_n_i), .valid_i(valid_i), .ready_o(ready_s), .data_i(data_i),
    .clear_flags_i(clear_flags_i), .valid_o(valid_s), .ready_i(ready_i), .data_o(data_s),
    .overflow_o(ov_s), .underflow_o(un_s), .overflow_flag_o(fo_s), .underflow_flag_o(fu_s));

  sat_accumulator #(.WORD_SIZE(W), .INT_BITS(8), .CHANNELS(C), .ACC_LEN(4), .SATURATE(0)) u_wrap (
    .clk_i(clk), .reset_n_i(reset_n_i), .valid_i(valid_i), .ready_o(ready_w), .data_i(data_i),
    .clear_flags_i(clear_flags_i), .valid_o(valid_w), .ready_i(ready_i), .data_o(data_w),
    .overflow_o(ov_w), .underflow_o(un_w), .overflow_flag_o(fo_w), .underflow_flag_o(fu_w));

  typedef struct {
    logic [31:0] data [2];
    logic [1:0]  ov [2];
    logic [1:0]  un [2];
  } exp_t;

  exp_t q[$];
  exp_t cur;
  bit   have_cur = 0;

  int errors = 0;
  int checks = 0;

  // Model state, index [dut][lane]; dut 0 saturates, dut 1 wraps.
  int m_acc [2][2];
  bit m_wov [2][2];
  bit m_wun [2][2];
  bit m_fov [2][2];
  bit m_fun [2][2];
  bit m_out = 0;
  int m_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++)
      for (int c = 0; c < 2; c++) begin
        m_acc[k][c] = 0; m_wov[k][c] = 0; m_wun[k][c] = 0; m_fov[k][c] = 0; m_fun[k][c] = 0;
      end
    m_out = 0; m_cnt = 0; have_cur = 0; q.delete();
  endtask

  task automatic model_update(input logic v, input logic [C*W-1:0] d, input logic rdy, input logic clr);
    bit ev_o [2][2];
    bit ev_u [2][2];
    bit bo, bu;
    exp_t e;
    for (int k = 0; k < 2; k++)
      for (int c = 0; c < 2; c++) begin ev_o[k][c] = 0; ev_u[k][c] = 0; end
    if (!m_out && v) begin
      for (int k = 0; k < 2; k++)
        for (int c = 0; c < 2; c++) begin
          int s;
          logic signed [15:0] dl;
          dl = d[c*W +: W];
          s = m_acc[k][c] + int'(dl);
          if (s > 32767) ev_o[k][c] = 1;
          if (s < -32768) ev_u[k][c] = 1;
          if (k == 0) begin
            if (s > 32767) s = 32767;
            if (s < -32768) s = -32768;
          end else begin
            if (s > 32767) s = s - 65536;
            if (s < -32768) s = s + 65536;
          end
          m_acc[k][c] = s;
          m_wov[k][c] |= ev_o[k][c];
          m_wun[k][c] |= ev_u[k][c];
        end
      if (m_cnt == 3) begin
        for (int k = 0; k < 2; k++) begin
          int a0, a1;
          a0 = m_acc[k][0]; a1 = m_acc[k][1];
          e.data[k] = {a1[15:0], a0[15:0]};
          e.ov[k] = {m_wov[k][1], m_wov[k][0]};
          e.un[k] = {m_wun[k][1], m_wun[k][0]};
        end
        q.push_back(e);
        m_out = 1; m_cnt = 0;
      end else begin
        m_cnt++;
      end
    end else if (m_out && rdy) begin
      m_out = 0;
      for (int k = 0; k < 2; k++)
        for (int c = 0; c < 2; c++) begin m_acc[k][c] = 0; m_wov[k][c] = 0; m_wun[k][c] = 0; end
    end
    for (int k = 0; k < 2; k++)
      for (int c = 0; c < 2; c++) begin
        bo = clr ? 1'b0 : m_fov[k][c];
        bu = clr ? 1'b0 : m_fun[k][c];
        m_fov[k][c] = bo | (ev_o[k][c] & ~bu);
        m_fun[k][c] = bu | (ev_u[k][c] & ~bo);
      end
  endtask

  task automatic compare(input string tag);
    check({tag, " ready_s"}, 32'(ready_s), 32'(!m_out));
    check({tag, " valid_s"}, 32'(valid_s), 32'(m_out));
    check({tag, " valid_w"}, 32'(valid_w), 32'(m_out));
    if (m_out) begin
      if (!have_cur) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $error("FAIL %s scoreboard: observed=empty queue expected=pending result", tag);
        end else begin
          cur = q.pop_front();
          have_cur = 1;
        end
      end
      if (have_cur) begin
        check({tag, " data_s"}, data_s, cur.data[0]);
        check({tag, " data_w"}, data_w, cur.data[1]);
        check({tag, " ovun_s"}, {28'd0, ov_s, un_s}, {28'd0, cur.ov[0], cur.un[0]});
        check({tag, " ovun_w"}, {28'd0, ov_w, un_w}, {28'd0, cur.ov[1], cur.un[1]});
      end
    end else begin
      have_cur = 0;
    end
    check({tag, " flags_s"}, {28'd0, fo_s, fu_s},
          {28'd0, m_fov[0][1], m_fov[0][0], m_fun[0][1], m_fun[0][0]});
    check({tag, " flags_w"}, {28'd0, fo_w, fu_w},
          {28'd0, m_fov[1][1], m_fov[1][0], m_fun[1][1], m_fun[1][0]});
  endtask

  // Called at posedge+1; returns at the following posedge+1.
  task automatic step(input string tag, input logic v, input logic [15:0] d0, input logic [15:0] d1,
                      input logic rdy, input logic clr);
    valid_i = v; data_i = {d1, d0}; ready_i = rdy; clear_flags_i = clr;
    @(posedge clk);
    if (reset_n_i) model_update(v, {d1, d0}, rdy, clr);
    #1;
    compare(tag);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " ready"}, {30'd0, ready_s, ready_w}, 32'h3);
    check({tag, " valid"}, {30'd0, valid_s, valid_w}, 32'h0);
    check({tag, " data_s"}, data_s, 32'h0);
    check({tag, " data_w"}, data_w, 32'h0);
    check({tag, " bits"}, {16'd0, ov_s, un_s, fo_s, fu_s, ov_w, un_w, fo_w, fu_w}, 32'h0);
  endtask

  // Asynchronous reset between edges: outputs must clear before any clock edge.
  task automatic async_reset(input string tag);
    #2 reset_n_i = 1'b0;
    #1 check_reset_outputs(tag);
    model_reset();
    @(posedge clk);
    #1 reset_n_i = 1'b1;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_reset_outputs("por");
    reset_n_i = 1'b1;

    // Normal window
    repeat (4) step("norm", 1, 16'h0100, 16'hFF00, 0, 0);
    step("norm_hold", 0, 16'h0, 16'h0, 0, 0);
    step("norm_rel", 0, 16'h0, 16'h0, 1, 0);

    // Overflow on lane0, underflow on lane1
    repeat (4) step("satw", 1, 16'h7000, 16'h9000, 0, 0);
    step("satw_rel", 0, 16'h0, 16'h0, 1, 0);
    step("clr1", 0, 16'h0, 16'h0, 0, 1);

    // Wrap-specific pattern
    step("wrap", 1, 16'h7000, 16'h0001, 0, 0);
    step("wrap", 1, 16'h7000, 16'h0002, 0, 0);
    step("wrap", 1, 16'h0000, 16'h0003, 0, 0);
    step("wrap", 1, 16'h0000, 16'h0004, 0, 0);
    step("wrap_rel", 0, 16'h0, 16'h0, 1, 1);

    // Backpressure with valid_i held high
    repeat (4) step("bp", 1, 16'h0011, 16'hFFFE, 0, 0);
    repeat (3) step("bp_hold", 1, 16'h1234, 16'h4321, 0, 0);
    step("bp_rel", 1, 16'h1234, 16'h4321, 1, 0);
    repeat (4) step("bp_next", 1, 16'h0010, 16'h0020, 0, 0);
    step("bp_next_rel", 0, 16'h0, 16'h0, 1, 0);

    // Sticky: underflow first, then overflow must not set the other flag
    repeat (4) step("stk_un", 1, 16'h9000, 16'h0000, 0, 0);
    step("stk_un_rel", 0, 16'h0, 16'h0, 1, 0);
    repeat (4) step("stk_ov", 1, 16'h7000, 16'h0000, 0, 0);
    step("stk_ov_rel", 0, 16'h0, 16'h0, 1, 0);
    step("stk_clr", 0, 16'h0, 16'h0, 0, 1);

    // Clear in the same cycle as an overflow event
    step("clrev", 1, 16'h7000, 16'h8000, 0, 0);
    step("clrev", 1, 16'h7000, 16'h8000, 0, 1);
    step("clrev", 1, 16'h0000, 16'h0000, 0, 0);
    step("clrev", 1, 16'h0000, 16'h0000, 0, 0);
    step("clrev_rel", 0, 16'h0, 16'h0, 1, 0);

    // Reset mid-window, then a fresh window of post-reset beats only
    repeat (2) step("pre_rst", 1, 16'h0100, 16'h0200, 0, 0);
    async_reset("rst_mid");
    repeat (4) step("post_rst", 1, 16'h0001, 16'hFFFF, 0, 0);
    step("post_rst_hold", 0, 16'h0, 16'h0, 0, 0);

    // Reset while a result is pending
    async_reset("rst_out");
    step("after_rst_out", 0, 16'h0, 16'h0, 1, 0);

    check("queue_empty", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
